// File: rtl/modulo5_pkg.sv
`default_nettype none
// modulo5_pkg: FSM state codes, remainder constants and the one-bit mod-5 step
// shared by the stream controller.
package modulo5_pkg;

  localparam int MODULUS = 5;
  localparam int REM_W   = 3;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_CLEAR  = 3'd1;
  localparam state_t ST_SHIFT  = 3'd2;
  localparam state_t ST_SETTLE = 3'd3;
  localparam state_t ST_RESULT = 3'd4;

  // {rem, b} is 2*rem + b (at most 9 for a legal rem), so one conditional subtract suffices.
  function automatic logic [REM_W-1:0] mod5_step(input logic [REM_W-1:0] rem, input logic b);
    logic [REM_W:0] w_acc;
    w_acc = {rem, b};
    if (w_acc >= (REM_W+1)'(MODULUS))
      w_acc = w_acc - (REM_W+1)'(MODULUS);
    return w_acc[REM_W-1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/modulo5_stream_ctrl_msb_serializer.sv
`default_nettype none
// msb_serializer: parallel-load shift register presenting its MSB, with a bit
// counter whose done flag marks the last bit of the word.
module msb_serializer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_shift,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_bit,
  output logic             o_done
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] r_shift;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (i_load) begin
      r_shift <= i_data;
      r_cnt   <= CNT_W'(WIDTH - 1);
    end else if (i_shift) begin
      r_shift <= r_shift << 1;
      if (r_cnt != '0)
        r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_bit  = r_shift[WIDTH-1];
  assign o_done = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/modulo5_stream_ctrl.sv
`default_nettype none
// modulo5_stream_ctrl: accepts a word, streams it MSB-first into an external
// serial mod-5 detector and returns its remainder, cross-checked by a shadow.
module modulo5_stream_ctrl
  import modulo5_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [2:0]       out_remainder,
  output logic             out_divisible,
  output logic             out_error,
  output logic             busy,
  output logic             det_clear,
  output logic             det_bit,
  input  logic [2:0]       det_remainder
);

  state_t           r_state;
  logic [WIDTH-1:0] r_out_data;
  logic [REM_W-1:0] r_shadow;
  logic [REM_W-1:0] r_remainder;
  logic             r_divisible;
  logic             r_error;

  logic w_accept;
  logic w_shift;
  logic w_ser_bit;
  logic w_ser_done;

  assign w_accept = (r_state == ST_IDLE) && in_valid;
  assign w_shift  = (r_state == ST_SHIFT);

  msb_serializer #(
    .WIDTH (WIDTH)
  ) u_serializer (
    .clk     (clock),
    .rst     (reset),
    .i_load  (w_accept),
    .i_shift (w_shift),
    .i_data  (in_data),
    .o_bit   (w_ser_bit),
    .o_done  (w_ser_done)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_out_data  <= '0;
      r_shadow    <= '0;
      r_remainder <= '0;
      r_divisible <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_out_data <= in_data;
            r_shadow   <= '0;
            r_state    <= ST_CLEAR;
          end
        end
        ST_CLEAR: r_state <= ST_SHIFT;
        ST_SHIFT: begin
          // Shadow tracks the same bits the detector sees, independently of it.
          r_shadow <= mod5_step(r_shadow, w_ser_bit);
          if (w_ser_done)
            r_state <= ST_SETTLE;
        end
        ST_SETTLE: begin
          r_remainder <= det_remainder;
          r_divisible <= (det_remainder == 3'd0);
          r_error     <= (det_remainder != r_shadow);
          r_state     <= ST_RESULT;
        end
        ST_RESULT: begin
          if (out_ready)
            r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready      = (r_state == ST_IDLE);
  assign out_valid     = (r_state == ST_RESULT);
  assign busy          = (r_state != ST_IDLE);
  assign det_clear     = (r_state == ST_CLEAR);
  assign det_bit       = w_shift & w_ser_bit;
  assign out_data      = r_out_data;
  assign out_remainder = r_remainder;
  assign out_divisible = r_divisible;
  assign out_error     = r_error;

endmodule
`default_nettype wire

// File: tb/tb_modulo5_stream_ctrl.sv
`default_nettype none
// tb_modulo5_stream_ctrl: directed plus randomized checks of the mod-5 stream
// controller against a behavioural detector and arithmetic reference.
module tb_modulo5_stream_ctrl;

  localparam int WIDTH = 8;

  logic             clock = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [2:0]       out_remainder;
  logic             out_divisible;
  logic             out_error;
  logic             busy;
  logic             det_clear;
  logic             det_bit;
  logic [2:0]       det_remainder;

  int vectors     = 0;
  int miscompares = 0;

  bit         stub_en  = 1'b0;
  logic [2:0] stub_val = 3'd0;
  logic [2:0] det_rem_r = 3'd0;

  int cyc = 0;
  int acc_cyc[$];
  int res_q[$];

  always #5 clock = ~clock;

  modulo5_stream_ctrl #(.WIDTH(WIDTH)) dut (
    .clock         (clock),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_remainder (out_remainder),
    .out_divisible (out_divisible),
    .out_error     (out_error),
    .busy          (busy),
    .det_clear     (det_clear),
    .det_bit       (det_bit),
    .det_remainder (det_remainder)
  );

  // Behavioural serial detector: rem <= (2*rem + bit) mod 5, cleared by reset | det_clear.
  always @(posedge clock) begin
    if (reset || det_clear)
      det_rem_r <= 3'd0;
    else
      det_rem_r <= 3'((2 * int'(det_rem_r) + int'(det_bit)) % 5);
  end
  assign det_remainder = stub_en ? stub_val : det_rem_r;

  always @(posedge clock) begin
    cyc++;
    if (!reset && in_valid && in_ready)
      acc_cyc.push_back(cyc);
    if (!reset && out_valid && out_ready)
      res_q.push_back(int'(out_remainder));
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_word(input logic [WIDTH-1:0] x, input int hold);
    int exp_true;
    int exp_rem;
    exp_true = int'(x) % 5;
    exp_rem  = stub_en ? int'(stub_val) : exp_true;
    @(negedge clock);
    in_valid = 1'b1;
    in_data  = x;
    chk("in_ready_idle", in_ready, 1);
    @(posedge clock);
    #1;
    in_valid = 1'($urandom_range(0, 1));
    in_data  = WIDTH'($urandom);
    for (int k = 0; k <= WIDTH + 2; k++) begin
      @(negedge clock);
      chk("busy", busy, 1);
      chk("in_ready_busy", in_ready, 0);
      chk("det_clear", det_clear, k == 0);
      if (k >= 1 && k <= WIDTH)
        chk("det_bit", det_bit, x[WIDTH-k]);
      else
        chk("det_bit_quiet", det_bit, 0);
      chk("out_valid_latency", out_valid, k == WIDTH + 2);
      if (k < WIDTH + 2)
        out_ready = 1'($urandom_range(0, 1));
    end
    chk("out_data", out_data, x);
    chk("out_remainder", out_remainder, exp_rem);
    chk("out_divisible", out_divisible, exp_rem == 0);
    chk("out_error", out_error, exp_rem != exp_true);
    out_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      @(negedge clock);
      chk("hold_valid", out_valid, 1);
      chk("hold_data", out_data, x);
      chk("hold_remainder", out_remainder, exp_rem);
      chk("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("handshake_valid_drop", out_valid, 0);
    chk("handshake_in_ready", in_ready, 1);
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_det_clear", det_clear, 0);
    chk("rst_det_bit", det_bit, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_remainder", out_remainder, 0);
    chk("rst_out_divisible", out_divisible, 0);
    chk("rst_out_error", out_error, 0);
    reset = 1'b0;

    do_word(8'd7, 0);
    do_word(8'd255, 0);
    do_word(8'd0, 0);
    do_word(8'd254, 0);

    // Back-to-back with in_valid held; data swapped just after the first accept.
    acc_cyc.delete();
    res_q.delete();
    @(negedge clock);
    in_valid  = 1'b1;
    in_data   = 8'd10;
    out_ready = 1'b1;
    for (int t = 0; t < 40 && acc_cyc.size() < 1; t++) @(negedge clock);
    in_data = 8'd13;
    for (int t = 0; t < 40 && acc_cyc.size() < 2; t++) begin
      @(negedge clock);
      chk("b2b_in_ready", in_ready, !busy);
    end
    in_valid = 1'b0;
    for (int t = 0; t < 40 && res_q.size() < 2; t++) @(negedge clock);
    out_ready = 1'b0;
    chk("b2b_accepts", acc_cyc.size(), 2);
    chk("b2b_results", res_q.size(), 2);
    if (acc_cyc.size() >= 2)
      chk("b2b_period", acc_cyc[1] - acc_cyc[0], WIDTH + 4);
    if (res_q.size() >= 2) begin
      chk("b2b_rem0", res_q[0], 0);
      chk("b2b_rem1", res_q[1], 3);
    end

    do_word(8'd13, 5);

    // Reset in the middle of SHIFT, after four bits of 200.
    @(negedge clock);
    in_valid = 1'b1;
    in_data  = 8'd200;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    repeat (6) @(negedge clock);
    reset = 1'b1;
    #1;
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_det_bit", det_bit, 0);
    chk("midrst_det_clear", det_clear, 0);
    chk("midrst_out_data", out_data, 0);
    chk("midrst_out_remainder", out_remainder, 0);
    @(negedge clock);
    reset = 1'b0;
    do_word(8'd200, 0);

    stub_en  = 1'b1;
    stub_val = 3'd1;
    do_word(8'd10, 0);
    stub_en  = 1'b0;

    for (int v = 0; v < 256; v++)
      do_word(WIDTH'(v), int'($urandom_range(0, 2)));
    for (int r = 0; r < 20; r++)
      do_word(WIDTH'($urandom), int'($urandom_range(0, 4)));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
